// File: rtl/armaria_io_pkg.sv
// Shared constants for the operator I/O path: default bus widths, button polarity
// and a constant-function log2 used to size counters and pointers.
package armaria_io_pkg;

    localparam int   IO_WIDTH_DEFAULT   = 16;
    localparam int   DATA_WIDTH_DEFAULT = 32;
    localparam logic BUTTON_PRESSED     = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Button conditioner: 2-flop sync, stability counter, one-cycle press pulse on the
// debounced press edge. Latency 2 + DEBOUNCE_CYCLES cycles to the pulse; no backpressure.
module input_debouncer
    import armaria_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int            CW   = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          enter_s;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    assign enter_s = sync[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync    <= {2{~BUTTON_PRESSED}};
            level   <= ~BUTTON_PRESSED;
            level_d <= ~BUTTON_PRESSED;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], raw};
            level_d <= level;
            if (enter_s == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= enter_s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // The pulse lines up with the cycle in which the new debounced level is visible.
    assign press = (level_d != BUTTON_PRESSED) && (level == BUTTON_PRESSED);

endmodule

// File: rtl/human_input_unit.sv
// Captures the switch bank on each debounced enter press into a fall-through FIFO.
// Press to data_valid in 2 + DEBOUNCE_CYCLES + 1 cycles; a press into a full FIFO is dropped and flagged.
module human_input_unit
    import armaria_io_pkg::*;
#(
    parameter int IO_WIDTH        = IO_WIDTH_DEFAULT,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH      = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [IO_WIDTH-1:0]               sw,
    input  logic                              enter_raw,
    input  logic                              read_request,
    input  logic                              clear_overflow,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              data_valid,
    output logic                              fifo_full,
    output logic                              overflow,
    output logic [clog2(FIFO_DEPTH+1)-1:0]    word_count
);

    localparam int            PW         = clog2(FIFO_DEPTH);
    localparam int            CW         = clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [IO_WIDTH-1:0] sw_m;
    logic [IO_WIDTH-1:0] sw_s;
    logic                push;
    logic                do_pop;
    logic                do_push;
    logic                drop;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [IO_WIDTH-1:0] mem [FIFO_DEPTH];

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter (
        .clock (clock),
        .reset (reset),
        .raw   (enter_raw),
        .press (push)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    // A pop frees the slot the same edge, so a full FIFO still accepts a concurrent push.
    assign data_valid = (count != '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign do_pop     = read_request && data_valid;
    assign do_push    = push && (!fifo_full || do_pop);
    assign drop       = push && fifo_full && !do_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= sw_s;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    assign word_count = count;
    assign data_out   = data_valid ? DATA_WIDTH'(mem[rd_ptr]) : '0;

endmodule
